// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL lock monitor / reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;

  // One shared counter covers every state, so size it for the longest wait.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst_n.
// Runs on the PLL reference clock so it keeps working while unlocked.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count,
  output logic [1:0] state
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

  logic          w_lock_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic [7:0]    r_retry;
  logic [7:0]    r_loss;

  sync2 #(.W(1)) u_lock_sync (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // Outputs are set alongside each transition so they move on the state edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RESET_PLL;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_retry     <= '0;
      r_loss      <= '0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout landing on the same cycle.
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TMO_LAST) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_retry   <= sat_inc8(r_retry);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_loss  <= sat_inc8(r_loss);
          end else if (r_cnt == STB_LAST) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RUN: begin
          // Lock loss re-qualifies without re-pulsing the PLL reset.
          if (!w_lock_s) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b0;
            r_loss      <= sat_inc8(r_loss);
          end
        end
        default: begin
          r_state     <= RESET_PLL;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst_n   = r_sys_rst_n;
  assign locked      = w_lock_s;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scenario bench for pll_reset_ctrl with PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
module tb_pll_reset_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic [7:0] retry_count;
  logic [7:0] loss_count;
  logic [1:0] state;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .locked      (locked),
    .retry_count (retry_count),
    .loss_count  (loss_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   nchk = 0;
  int   nerr = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t pop();
    exp_t x;
    x.nm = "empty";
    x.v  = 8'hxx;
    if (q.size() > 0) x = q.pop_front();
    return x;
  endfunction

  // Hold reset, then release just after an edge: the next posedge is edge 1.
  task automatic rel(input logic lk);
    reset_n  = 1'b0;
    pll_lock = lk;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    q.push_back('{"rst_pll_rst", 8'd1});
    q.push_back('{"rst_sys_rst_n", 8'd0});
    q.push_back('{"rst_locked", 8'd0});
    q.push_back('{"rst_retry", 8'd0});
    q.push_back('{"rst_loss", 8'd0});
    q.push_back('{"rst_state", 8'd0});
    repeat (3) tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])     begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    e = pop(); nchk++; if (sys_rst_n !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    e = pop(); nchk++; if (locked !== e.v[0])      begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, locked, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v)    begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    e = pop(); nchk++; if (loss_count !== e.v)     begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, loss_count, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])     begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
  endtask

  task automatic test_timeout();
    rel(1'b0);
    q.push_back('{"to_pll_rst_e3", 8'd1});
    q.push_back('{"to_pll_rst_e4", 8'd0});
    q.push_back('{"to_state_e4", 8'd1});
    q.push_back('{"to_pll_rst_e35", 8'd0});
    q.push_back('{"to_pll_rst_e36", 8'd1});
    q.push_back('{"to_retry_e36", 8'd1});
    q.push_back('{"to_retry_e300", 8'd8});
    repeat (3) tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    repeat (31) tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    repeat (264) tick();
    e = pop(); nchk++; if (retry_count !== e.v) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
  endtask

  // WAIT_LOCK is entered at edge 4; lock is first sampled high at edge E=10.
  task automatic test_lock();
    rel(1'b0);
    repeat (9) tick();
    pll_lock = 1'b1;
    q.push_back('{"lk_locked_E", 8'd0});
    q.push_back('{"lk_locked_E1", 8'd1});
    q.push_back('{"lk_state_E1", 8'd1});
    q.push_back('{"lk_state_E2", 8'd2});
    q.push_back('{"lk_sys_E9", 8'd0});
    q.push_back('{"lk_sys_E10", 8'd1});
    q.push_back('{"lk_state_E10", 8'd3});
    q.push_back('{"lk_retry", 8'd0});
    tick();
    e = pop(); nchk++; if (locked !== e.v[0])    begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, locked, e.v); end
    tick();
    e = pop(); nchk++; if (locked !== e.v[0])    begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, locked, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    repeat (7) tick();
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    tick();
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v)  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
  endtask

  // STABLE entered at edge 7; lock sampled low only at edge 11 (STABLE cycle 5).
  // Then a lock loss in RUN: first sampled low at edge 25.
  task automatic test_glitch_and_loss();
    rel(1'b0);
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (6) tick();
    pll_lock = 1'b0;
    q.push_back('{"gl_state_e13", 8'd1});
    q.push_back('{"gl_loss_e13", 8'd1});
    q.push_back('{"gl_sys_e13", 8'd0});
    q.push_back('{"gl_state_e21", 8'd2});
    q.push_back('{"gl_sys_e21", 8'd0});
    q.push_back('{"gl_sys_e22", 8'd1});
    tick();
    pll_lock = 1'b1;
    repeat (2) tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (loss_count !== e.v)   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, loss_count, e.v); end
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    repeat (8) tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    tick();
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    repeat (2) tick();
    pll_lock = 1'b0;
    q.push_back('{"rl_sys_E1", 8'd1});
    q.push_back('{"rl_sys_E2", 8'd0});
    q.push_back('{"rl_state_E2", 8'd1});
    q.push_back('{"rl_loss_E2", 8'd2});
    q.push_back('{"rl_pll_rst_E2", 8'd0});
    q.push_back('{"rl_pll_rst_E5", 8'd0});
    repeat (2) tick();
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    tick();
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (loss_count !== e.v)   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, loss_count, e.v); end
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    repeat (3) tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
  endtask

  // Lock sampled at edge 34 gives lock_s=1 for the edge-36 decision (cnt==31).
  task automatic test_timeout_boundary();
    rel(1'b0);
    repeat (33) tick();
    pll_lock = 1'b1;
    q.push_back('{"tb_state_e36", 8'd2});
    q.push_back('{"tb_retry_e36", 8'd0});
    q.push_back('{"tb_pll_rst_e36", 8'd0});
    repeat (3) tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v)  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
  endtask

  // Each retry round is 4 + 32 edges with lock held low.
  task automatic test_saturation();
    rel(1'b0);
    q.push_back('{"sat_retry_254", 8'd254});
    q.push_back('{"sat_retry_255", 8'd255});
    q.push_back('{"sat_retry_260", 8'd255});
    repeat (254 * 36) tick();
    e = pop(); nchk++; if (retry_count !== e.v) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    repeat (36) tick();
    e = pop(); nchk++; if (retry_count !== e.v) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    repeat (5 * 36) tick();
    e = pop(); nchk++; if (retry_count !== e.v) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
  endtask

  // Timeout at 36, relock sampled at 41 -> RUN at 51, loss at 53 -> WAIT at 55,
  // relock sampled at 56 -> RUN at 66; then reset mid-cycle.
  task automatic test_reset_in_run();
    rel(1'b0);
    repeat (40) tick();
    pll_lock = 1'b1;
    repeat (12) tick();
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    q.push_back('{"rr_state_run", 8'd3});
    q.push_back('{"rr_retry_run", 8'd1});
    q.push_back('{"rr_loss_run", 8'd1});
    q.push_back('{"rr_sys_async", 8'd0});
    q.push_back('{"rr_pll_rst_async", 8'd1});
    q.push_back('{"rr_retry_async", 8'd0});
    q.push_back('{"rr_loss_async", 8'd0});
    q.push_back('{"rr_state_async", 8'd0});
    repeat (11) tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v)  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    e = pop(); nchk++; if (loss_count !== e.v)   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, loss_count, e.v); end
    #2;
    reset_n = 1'b0;
    #1;
    e = pop(); nchk++; if (sys_rst_n !== e.v[0]) begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, sys_rst_n, e.v); end
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    e = pop(); nchk++; if (retry_count !== e.v)  begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, retry_count, e.v); end
    e = pop(); nchk++; if (loss_count !== e.v)   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, loss_count, e.v); end
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
    tick();
    tick();
    reset_n = 1'b1;
    q.push_back('{"rr_pll_rst_e3", 8'd1});
    q.push_back('{"rr_pll_rst_e4", 8'd0});
    q.push_back('{"rr_state_e5", 8'd2});
    repeat (3) tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    tick();
    e = pop(); nchk++; if (pll_rst !== e.v[0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, pll_rst, e.v); end
    tick();
    e = pop(); nchk++; if (state !== e.v[1:0])   begin nerr++; $display("FAIL %s: got %0d want %0d", e.nm, state, e.v); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock();
    test_glitch_and_loss();
    test_timeout_boundary();
    test_saturation();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
